// File: rtl/jtframe_vtgen.sv
// jtframe_vtgen: video timing generator (raster counters, blanking, syncs, field)
// Define JTFRAME_VTGEN_INTERLACE_EN for interlaced fields with a half-line vsync shift.
module jtframe_vtgen #(
    parameter int CNTW     = 10,
    parameter int HTOTAL   = 400,
    parameter int HB_START = 320,
    parameter int HB_END   = 0,
    parameter int HS_START = 336,
    parameter int HS_END   = 368,
    parameter int VTOTAL   = 262,
    parameter int VB_START = 240,
    parameter int VB_END   = 0,
    parameter int VS_START = 244,
    parameter int VS_END   = 247
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pxl_cen,
    input  logic            interlace,
    output logic [CNTW-1:0] hcnt,
    output logic [CNTW-1:0] vcnt,
    output logic            LHBL,
    output logic            LVBL,
    output logic            hs,
    output logic            vs,
    output logic            field,
    output logic            frame_start
);
    localparam logic [CNTW-1:0] H_LAST  = CNTW'(HTOTAL - 1);
    localparam logic [CNTW-1:0] V_LAST0 = CNTW'(VTOTAL - 1);
    localparam logic [CNTW-1:0] V_LAST1 = CNTW'(VTOTAL);
    localparam logic [CNTW-1:0] VSH0    = CNTW'(HS_START);
    localparam logic [CNTW-1:0] VSH1    = CNTW'((HS_START + HTOTAL / 2) % HTOTAL);
    localparam logic [CNTW-1:0] VS_S    = CNTW'(VS_START);
    localparam logic [CNTW-1:0] VS_E    = CNTW'(VS_END);

    logic            lace, h_end, v_wrap, f_nxt;
    logic [CNTW-1:0] h_nxt, v_nxt, vlast, vsh;

    // lo <= x < hi as one modular compare, so a zero lower bound needs no special case
    function automatic logic in_rng(input logic [CNTW-1:0] x, input int lo, input int hi);
        return CNTW'(x - CNTW'(lo)) < CNTW'(hi - lo);
    endfunction

    always_comb begin
        h_end  = hcnt == H_LAST;
        vlast  = field && lace ? V_LAST1 : V_LAST0;
        v_wrap = h_end && vcnt == vlast;
        h_nxt  = h_end ? '0 : hcnt + 1'b1;
        v_nxt  = v_wrap ? '0 : h_end ? vcnt + 1'b1 : vcnt;
        f_nxt  = v_wrap ? lace && !field : field;
        vsh    = f_nxt ? VSH1 : VSH0;
    end

`ifdef JTFRAME_VTGEN_INTERLACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lace <= 1'b0;
        else if (pxl_cen && v_wrap) lace <= interlace;
    end
`else
    logic unused_interlace;
    assign lace             = 1'b0;
    assign unused_interlace = interlace;
`endif

    // every output is computed from the next position so it lines up with hcnt/vcnt
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt        <= '0;
            vcnt        <= '0;
            LHBL        <= 1'b0;
            LVBL        <= 1'b0;
            hs          <= 1'b0;
            vs          <= 1'b0;
            field       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pxl_cen) begin
                hcnt        <= h_nxt;
                vcnt        <= v_nxt;
                field       <= f_nxt;
                LHBL        <= in_rng(h_nxt, HB_END, HB_START);
                LVBL        <= in_rng(v_nxt, VB_END, VB_START);
                hs          <= in_rng(h_nxt, HS_START, HS_END);
                vs          <= {v_nxt, h_nxt} >= {VS_S, vsh} && {v_nxt, h_nxt} < {VS_E, vsh};
                frame_start <= h_nxt == '0 && v_nxt == '0;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_vtgen.sv
// tb_jtframe_vtgen: directed vector tables for jtframe_vtgen on a scaled-down raster
// (40 px x 26 lines) so whole frames and field pairs fit in a short run.
module tb_jtframe_vtgen;
    localparam int CNTW = 6;

    logic            clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0, interlace = 1'b0;
    logic [CNTW-1:0] hcnt, vcnt;
    logic            LHBL, LVBL, hs, vs, field, frame_start;

    jtframe_vtgen #(
        .CNTW(CNTW), .HTOTAL(40), .HB_START(32), .HB_END(4), .HS_START(34), .HS_END(37),
        .VTOTAL(26), .VB_START(22), .VB_END(2), .VS_START(23), .VS_END(25)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .interlace(interlace),
        .hcnt(hcnt), .vcnt(vcnt), .LHBL(LHBL), .LVBL(LVBL), .hs(hs), .vs(vs),
        .field(field), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        bit lace;
        int v, h;
        bit lhbl, lvbl, hs, vs, field, fs;
    } vec_t;

    vec_t p1[22];
    vec_t p3[15];
    int n_vec = 0, n_bad = 0, pos = 0, div = 1, stab_bad = 0, fs_cnt = 0, fs_last = -1;

    function automatic logic [31:0] obs();
        return 32'({vcnt, hcnt, LHBL, LVBL, hs, vs, field, frame_start});
    endfunction

    function automatic logic [31:0] exp_of(input vec_t t);
        return 32'({CNTW'(t.v), CNTW'(t.h), t.lhbl, t.lvbl, t.hs, t.vs, t.field, t.fs});
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h ({vcnt,hcnt,LHBL,LVBL,hs,vs,field,frame_start})",
                     name, idx, act, expv);
        end
    endtask

    task automatic tick(input bit en);
        logic [31:0] snap;
        pxl_cen = en;
        snap = obs();
        @(posedge clk);
        #1;
        if (!en && ((obs() >> 1) != (snap >> 1) || frame_start)) stab_bad++;
        if (en) pos++;
        if (frame_start) begin
            fs_cnt++;
            fs_last = pos;
        end
    endtask

    task automatic run_to(input int tgt);
        int guard = 0;
        while (pos < tgt && guard < 20000) begin
            for (int k = 1; k < div; k++) tick(1'b0);
            tick(1'b1);
            guard++;
        end
        if (pos != tgt) begin
            n_vec++;
            n_bad++;
            $display("FAIL run_to: reached pixel %0d expected %0d", pos, tgt);
        end
    endtask

    task automatic apply(input string name, input int idx, input vec_t t);
        interlace = t.lace;
        run_to(t.pos);
        check(name, idx, obs(), exp_of(t));
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        pxl_cen = 1'b0;
        #3;
        check("reset", 0, obs(), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pos = 0;
        fs_cnt = 0;
        fs_last = -1;
    endtask

    initial begin
        // pos, lace, v, h, LHBL, LVBL, hs, vs, field, frame_start
        p1 = '{
            '{1,    0, 0,  1,  0, 0, 0, 0, 0, 0},
            '{3,    0, 0,  3,  0, 0, 0, 0, 0, 0},
            '{4,    0, 0,  4,  1, 0, 0, 0, 0, 0},
            '{31,   0, 0,  31, 1, 0, 0, 0, 0, 0},
            '{32,   0, 0,  32, 0, 0, 0, 0, 0, 0},
            '{33,   0, 0,  33, 0, 0, 0, 0, 0, 0},
            '{34,   0, 0,  34, 0, 0, 1, 0, 0, 0},
            '{36,   0, 0,  36, 0, 0, 1, 0, 0, 0},
            '{37,   0, 0,  37, 0, 0, 0, 0, 0, 0},
            '{79,   0, 1,  39, 0, 0, 0, 0, 0, 0},
            '{80,   0, 2,  0,  0, 1, 0, 0, 0, 0},
            '{85,   0, 2,  5,  1, 1, 0, 0, 0, 0},
            '{879,  0, 21, 39, 0, 1, 0, 0, 0, 0},
            '{880,  0, 22, 0,  0, 0, 0, 0, 0, 0},
            '{953,  0, 23, 33, 0, 0, 0, 0, 0, 0},
            '{954,  0, 23, 34, 0, 0, 1, 1, 0, 0},
            '{970,  0, 24, 10, 1, 0, 0, 1, 0, 0},
            '{1033, 0, 25, 33, 0, 0, 0, 1, 0, 0},
            '{1034, 0, 25, 34, 0, 0, 1, 0, 0, 0},
            '{1039, 0, 25, 39, 0, 0, 0, 0, 0, 0},
            '{1040, 0, 0,  0,  0, 0, 0, 0, 0, 1},
            '{1041, 0, 0,  1,  0, 0, 0, 0, 0, 0}
        };
`ifdef JTFRAME_VTGEN_INTERLACE_EN
        p3 = '{
            '{1040, 1, 0,  0,  0, 0, 0, 0, 0, 1},
            '{2080, 1, 0,  0,  0, 0, 0, 0, 1, 1},
            '{3013, 1, 23, 13, 1, 0, 0, 0, 1, 0},
            '{3014, 1, 23, 14, 1, 0, 0, 1, 1, 0},
            '{3093, 1, 25, 13, 1, 0, 0, 1, 1, 0},
            '{3094, 1, 25, 14, 1, 0, 0, 0, 1, 0},
            '{3120, 1, 26, 0,  0, 0, 0, 0, 1, 0},
            '{3159, 1, 26, 39, 0, 0, 0, 0, 1, 0},
            '{3160, 1, 0,  0,  0, 0, 0, 0, 0, 1},
            '{4200, 1, 0,  0,  0, 0, 0, 0, 1, 1},
            '{5240, 0, 26, 0,  0, 0, 0, 0, 1, 0},
            '{5280, 0, 0,  0,  0, 0, 0, 0, 0, 1},
            '{6319, 0, 25, 39, 0, 0, 0, 0, 0, 0},
            '{6320, 0, 0,  0,  0, 0, 0, 0, 0, 1},
            '{7360, 0, 0,  0,  0, 0, 0, 0, 0, 1}
        };
`else
        p3 = '{
            '{1040, 1, 0,  0,  0, 0, 0, 0, 0, 1},
            '{2080, 1, 0,  0,  0, 0, 0, 0, 0, 1},
            '{3013, 1, 23, 13, 1, 0, 0, 0, 0, 0},
            '{3014, 1, 23, 14, 1, 0, 0, 0, 0, 0},
            '{3093, 1, 25, 13, 1, 0, 0, 1, 0, 0},
            '{3094, 1, 25, 14, 1, 0, 0, 1, 0, 0},
            '{3120, 1, 0,  0,  0, 0, 0, 0, 0, 1},
            '{3159, 1, 0,  39, 0, 0, 0, 0, 0, 0},
            '{3160, 1, 1,  0,  0, 0, 0, 0, 0, 0},
            '{4200, 1, 1,  0,  0, 0, 0, 0, 0, 0},
            '{5240, 0, 1,  0,  0, 0, 0, 0, 0, 0},
            '{5280, 0, 2,  0,  0, 1, 0, 0, 0, 0},
            '{6319, 0, 1,  39, 0, 0, 0, 0, 0, 0},
            '{6320, 0, 2,  0,  0, 1, 0, 0, 0, 0},
            '{7360, 0, 2,  0,  0, 1, 0, 0, 0, 0}
        };
`endif
        // full-rate pixel enable over one frame
        hard_reset();
        div = 1;
        foreach (p1[i]) apply("full_rate", i, p1[i]);
        check("fs_count", 0, 32'(fs_cnt), 32'd1);
        check("fs_where", 0, 32'(fs_last), 32'd1040);

        // same transitions with the enable high one clk in four
        hard_reset();
        div = 4;
        stab_bad = 0;
        foreach (p1[i]) apply("cen_div4", i, p1[i]);
        check("idle_stable", 0, 32'(stab_bad), 32'd0);
        check("fs_div4", 0, 32'(fs_last), 32'd1040);

        // interlace on, then dropped in the middle of an odd field
        hard_reset();
        div = 1;
        foreach (p3[i]) apply("interlace", i, p3[i]);

        // asynchronous reset in the middle of a line
        hard_reset();
        interlace = 1'b0;
        run_to(420);
        check("pre_rst", 0, obs(), 32'({CNTW'(10), CNTW'(20), 6'b110000}));
        #2 rst_n = 1'b0;
        #1 check("async_rst", 0, obs(), 32'd0);
        pxl_cen = 1'b1;
        @(posedge clk);
        #1 check("rst_hold", 0, obs(), 32'd0);
        rst_n = 1'b1;
        pos = 0;
        apply("after_rst", 0, p1[0]);
        apply("after_rst", 1, p1[10]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
